// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if
//   Bundles every signal between the divider arbiter, its requesters and the
//   shared divider core.
//   slave  : the arbiter side. It takes requests and operands, returns grants,
//            done pulses and results, and drives the divider start and operands.
//   master : the environment side, meaning the requesters plus the divider core.
//   Request side  : req, dividend_in, divisor_in, gnt, done, err, quotient_out,
//                   remainder_out, busy
//   Divider side  : div_strt, div_dividend, div_divisor, div_quotient,
//                   div_remainder, div_idle
interface divider_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] dividend_in;
   logic [N_REQ*WIDTH-1:0] divisor_in;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       done;
   logic                   err;
   logic [WIDTH-1:0]       quotient_out;
   logic [WIDTH-1:0]       remainder_out;
   logic                   busy;
   logic                   div_strt;
   logic [WIDTH-1:0]       div_dividend;
   logic [WIDTH-1:0]       div_divisor;
   logic [WIDTH-1:0]       div_quotient;
   logic [WIDTH-1:0]       div_remainder;
   logic                   div_idle;

   modport slave (
      input  req, dividend_in, divisor_in, div_quotient, div_remainder, div_idle,
      output gnt, done, err, quotient_out, remainder_out, busy,
             div_strt, div_dividend, div_divisor
   );

   modport master (
      output req, dividend_in, divisor_in, div_quotient, div_remainder, div_idle,
      input  gnt, done, err, quotient_out, remainder_out, busy,
             div_strt, div_dividend, div_divisor
   );
endinterface

// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one divider core among N_REQ requesters using round-robin arbitration.
//   It latches the winner's operands, pulses div_strt, and waits for the divider
//   to go busy and then idle again. It then returns the quotient, the remainder
//   and err to the winner with a one-cycle done pulse.
//   A zero divisor is answered directly without starting the divider.
//   If the divider never leaves idle after start, the arbiter times out and
//   returns err.
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset. It aborts any operation in flight,
//         so no done is issued for that operation.
//   bus : divider_arbiter_if.slave. It carries the request side and the
//         divider side.
module divider_arbiter #(
   parameter int N_REQ        = 4,
   parameter int WIDTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input logic              clk,
   input logic              rst,
   divider_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    ptr, owner, winner, idx;
   logic             found;
   logic [CW-1:0]    tmo_cnt;
   logic [WIDTH-1:0] win_dividend, win_divisor;
   logic [N_REQ-1:0] gnt_reg;
   logic             err_reg;
   logic [WIDTH-1:0] quo_reg, rem_reg, dvd_reg, dvs_reg;

   // Round-robin search: take the first set req at or after ptr, with wrap-around.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % N_REQ);
         if (!found && bus.req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign win_dividend = bus.dividend_in[winner*WIDTH +: WIDTH];
   assign win_divisor  = bus.divisor_in[winner*WIDTH +: WIDTH];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (found && bus.div_idle)
               state_nxt = (win_divisor == '0) ? RESP : ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY:
            if (!bus.div_idle)                     state_nxt = WAIT_DONE;
            else if (tmo_cnt == CW'(BUSY_TIMEOUT)) state_nxt = RESP;
         WAIT_DONE:
            if (bus.div_idle) state_nxt = RESP;
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Registered datapath: grant, operands, timeout counter, results, pointer.
   // The results register is loaded on the edge that enters RESP.
   // This makes the result valid together with done, and it stays held
   // until the next operation reaches RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_reg <= '0;
         owner   <= '0;
         ptr     <= '0;
         dvd_reg <= '0;
         dvs_reg <= '0;
         tmo_cnt <= '0;
         err_reg <= 1'b0;
         quo_reg <= '0;
         rem_reg <= '0;
      end else begin
         case (state)
            IDLE:
               if (state_nxt != IDLE) begin
                  gnt_reg <= N_REQ'(1) << winner;
                  owner   <= winner;
                  dvd_reg <= win_dividend;
                  dvs_reg <= win_divisor;
                  if (state_nxt == RESP) begin
                     err_reg <= 1'b1;
                     quo_reg <= '0;
                     rem_reg <= '0;
                  end
               end
            ISSUE:     tmo_cnt <= '0;
            WAIT_BUSY: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (state_nxt == RESP) begin
                  err_reg <= 1'b1;
                  quo_reg <= '0;
                  rem_reg <= '0;
               end
            end
            WAIT_DONE:
               if (state_nxt == RESP) begin
                  err_reg <= 1'b0;
                  quo_reg <= bus.div_quotient;
                  rem_reg <= bus.div_remainder;
               end
            RESP: begin
               gnt_reg <= '0;
               ptr     <= IW'((int'(owner) + 1) % N_REQ);
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      bus.div_strt = (state == ISSUE);
      bus.done     = (state == RESP) ? gnt_reg : '0;
      bus.busy     = (state != IDLE);
   end

   assign bus.gnt           = gnt_reg;
   assign bus.err           = err_reg;
   assign bus.quotient_out  = quo_reg;
   assign bus.remainder_out = rem_reg;
   assign bus.div_dividend  = dvd_reg;
   assign bus.div_divisor   = dvs_reg;
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter
//   Randomised scoreboard bench for divider_arbiter.
//   Each batch of simultaneous requests pushes its expected responses into a queue.
//   The expected serving order is the round-robin order taken from a model pointer.
//   The expected results come from plain / and %.
//   A separate monitor pops and compares on every done pulse.
//   A behavioural divider answers div_strt after a programmable busy time.
//   It can also be held stuck idle.
module tb_divider_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   divider_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   divider_arbiter #(.N_REQ(N), .WIDTH(W), .BUSY_TIMEOUT(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int id;
      int q;
      int r;
      bit err;
      int kind;   // 0 normal, 1 divide-by-zero, 2 divider timeout
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int strt_cnt = 0;
   int strt_cyc = 0;
   int gnt_cyc = 0;
   logic [N-1:0] prev_gnt = '0;
   int div_lat = 3;
   bit stuck = 1'b0;
   int div_cnt = 0;
   logic [W-1:0] da, db;
   int ptr_m = 0;
   int a[N];
   int b[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural divider. It samples start on the falling edge, stays busy
   // for div_lat cycles and then presents the results.
   always @(negedge clk) begin
      if (rst) begin
         bus.div_idle = 1'b1;
         div_cnt = 0;
      end else if (!stuck) begin
         if (bus.div_strt) begin
            da = bus.div_dividend;
            db = bus.div_divisor;
            bus.div_idle = 1'b0;
            div_cnt = div_lat;
         end else if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin
               bus.div_quotient  = (db == 0) ? '1 : da / db;
               bus.div_remainder = (db == 0) ? '1 : da % db;
               bus.div_idle = 1'b1;
            end
         end
      end
   end

   // Monitor and scoreboard
   always @(negedge clk) begin
      if (rst) begin
         prev_gnt = '0;
      end else begin
         if (bus.div_strt) begin
            strt_cnt++;
            strt_cyc = cyc;
         end
         if (bus.gnt != 0 && prev_gnt == 0) gnt_cyc = cyc;
         prev_gnt = bus.gnt;
         chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
         chk("done_onehot0", 32'($onehot0(bus.done)), 1);
         if (bus.done != 0) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: done=%b want no done", bus.done);
            end else begin
               e = exp_q.pop_front();
               chk("done_id", 32'(bus.done), 32'(1) << e.id);
               chk("gnt_at_done", 32'(bus.gnt), 32'(1) << e.id);
               chk("err", 32'(bus.err), 32'(e.err));
               chk("quotient", 32'(bus.quotient_out), e.q);
               chk("remainder", 32'(bus.remainder_out), e.r);
               if (e.kind == 1) chk("dz_latency", cyc - gnt_cyc, 0);
               if (e.kind == 2) chk("timeout_latency", cyc - strt_cyc, T + 2);
            end
         end
      end
   end

   // Runs one batch of requests that are raised together while the arbiter
   // is idle. With mess set, each granted requester drops req and scrambles
   // its operands while it is being served.
   task automatic run_batch(input logic [N-1:0] set, input bit mess);
      exp_t x;
      int i;
      int last;
      int nstrt;
      int s0;
      last = ptr_m;
      nstrt = 0;
      for (int k = 0; k < N; k++) begin
         i = (ptr_m + k) % N;
         if (set[i]) begin
            x.id = i;
            if (b[i] == 0) begin
               x.err = 1; x.q = 0; x.r = 0; x.kind = 1;
            end else if (stuck) begin
               x.err = 1; x.q = 0; x.r = 0; x.kind = 2; nstrt++;
            end else begin
               x.err = 0; x.q = a[i] / b[i]; x.r = a[i] % b[i]; x.kind = 0; nstrt++;
            end
            exp_q.push_back(x);
            last = i;
         end
      end
      ptr_m = (last + 1) % N;
      for (int j = 0; j < N; j++) begin
         bus.dividend_in[j*W +: W] = W'(a[j]);
         bus.divisor_in[j*W +: W]  = W'(b[j]);
      end
      s0 = strt_cnt;
      bus.req = set;
      for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
         @(negedge clk);
         for (int j = 0; j < N; j++) begin
            if (bus.done[j]) bus.req[j] = 1'b0;
            else if (mess && bus.gnt[j]) begin
               bus.req[j] = 1'b0;
               bus.dividend_in[j*W +: W] = W'($urandom);
               bus.divisor_in[j*W +: W]  = W'($urandom);
            end
         end
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL batch_timeout: %0d responses outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      bus.req = '0;
      @(negedge clk);
      chk("strt_count", strt_cnt - s0, nstrt);
      chk("busy_after", 32'(bus.busy), 0);
   endtask

   initial begin
      int st;
      rst = 1'b1;
      bus.req = '0;
      bus.dividend_in = '0;
      bus.divisor_in = '0;
      bus.div_quotient = '0;
      bus.div_remainder = '0;
      bus.div_idle = 1'b1;
      for (int j = 0; j < N; j++) begin a[j] = 1; b[j] = 1; end
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_strt", 32'(bus.div_strt), 0);
      chk("rst_q", 32'(bus.quotient_out), 0);
      chk("rst_r", 32'(bus.remainder_out), 0);
      chk("rst_dvd", 32'(bus.div_dividend), 0);
      chk("rst_dvs", 32'(bus.div_divisor), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic division on requester 0
      a[0] = 100; b[0] = 7;
      run_batch(4'b0001, 1'b0);

      // Divide by zero on requester 2
      a[2] = 9; b[2] = 0;
      run_batch(4'b0100, 1'b0);

      // All four requesters at once, twice
      for (int j = 0; j < N; j++) begin a[j] = $urandom_range(255, 0); b[j] = $urandom_range(255, 1); end
      run_batch(4'b1111, 1'b0);
      for (int j = 0; j < N; j++) begin a[j] = $urandom_range(255, 0); b[j] = $urandom_range(255, 1); end
      run_batch(4'b1111, 1'b0);

      // Divider stuck idle, so the arbiter times out
      stuck = 1'b1;
      a[1] = 20; b[1] = 3;
      run_batch(4'b0010, 1'b0);
      stuck = 1'b0;

      // Set the pointer to 2, then abort an operation with reset while in WAIT_DONE
      run_batch(4'b0010, 1'b0);
      div_lat = 12;
      a[0] = 50; b[0] = 5;
      bus.dividend_in[0 +: W] = W'(a[0]);
      bus.divisor_in[0 +: W]  = W'(b[0]);
      bus.req = 4'b0001;
      st = 0;
      for (int c = 0; c < 20 && !bus.div_strt; c++) @(negedge clk);
      if (!bus.div_strt) begin
         total++;
         bad++;
         $display("FAIL rst_abort_start: div_strt=0 want 1");
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_gnt", 32'(bus.gnt), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_done", 32'(bus.done), 0);
      rst = 1'b0;
      bus.req = '0;
      ptr_m = 0;
      div_lat = 3;
      @(negedge clk);
      a[0] = 77; b[0] = 6; a[2] = 201; b[2] = 13;
      run_batch(4'b0101, 1'b0);

      // Requester 3 drops req and changes its operands while being served
      a[3] = 200; b[3] = 9;
      run_batch(4'b1000, 1'b1);

      // Random batches
      for (int n = 0; n < 25; n++) begin
         for (int j = 0; j < N; j++) begin
            a[j] = $urandom_range(255, 0);
            b[j] = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(255, 1);
         end
         div_lat = $urandom_range(6, 2);
         run_batch(4'($urandom_range(15, 1)), 1'($urandom_range(1, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
